// File: rtl/input_queue_pkg.sv
// Shared defaults for the operator-input queue.
// Constants used by input_queue and debounce.
package input_queue_pkg;
    localparam int DATA_WIDTH_DEF      = 16;
    localparam int IN_WIDTH_DEF        = 4;
    localparam int DEPTH_LOG2_DEF      = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int SYNC_STAGES         = 2;
endpackage

// File: rtl/input_queue_debounce.sv
// Button synchroniser + debouncer producing a one-cycle press pulse.
// Presses are ignored until the button has been seen released after reset.
import input_queue_pkg::*;

module debounce #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic push
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] warm;
    logic [CNT_W-1:0]       cnt;
    logic                   level;
    logic                   ready;
    logic                   stable;
    logic                   stable_d;
    logic                   armed;

    assign level = sync[SYNC_STAGES-1];
    // Sync flops read 0 right after reset; wait until they carry real samples.
    assign ready = warm[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= '0;
            warm     <= '0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            armed    <= 1'b0;
            push     <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], raw};
            warm     <= {warm[SYNC_STAGES-2:0], 1'b1};
            stable_d <= stable;
            if (level == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
            if (ready && !level) begin
                armed <= 1'b1;
            end
            push <= stable & ~stable_d & armed;
        end
    end
endmodule

// File: rtl/input_queue.sv
// Debounced switch-capture FIFO feeding the CPU in port.
// Define INPUT_QUEUE_DROP_OLDEST_EN to overwrite the oldest entry when full.
import input_queue_pkg::*;

module input_queue #(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int IN_WIDTH        = IN_WIDTH_DEF,
    parameter int DEPTH_LOG2      = DEPTH_LOG2_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn,
    input  logic [IN_WIDTH-1:0]   sw,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [IN_WIDTH-1:0]   sw_s1;
    logic [IN_WIDTH-1:0]   sw_sync;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] word;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  wr_en;
    logic                  rd_adv;
    logic                  ovf_set;
    logic                  inc;
    logic                  dec;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk (clk),
        .rst (rst),
        .raw (btn),
        .push(push)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1   <= '0;
            sw_sync <= '0;
        end else begin
            sw_s1   <= sw;
            sw_sync <= sw_s1;
        end
    end

    assign word  = {{(DATA_WIDTH - IN_WIDTH){1'b0}}, sw_sync};
    assign valid = (count != '0);
    assign full  = (count == CNT_FULL);
    assign data  = valid ? mem[rd_ptr] : '0;

    always_comb begin
        pop = rd && valid;
`ifdef INPUT_QUEUE_DROP_OLDEST_EN
        wr_en   = push;
        rd_adv  = pop || (push && full);
`else
        wr_en   = push && (!full || pop);
        rd_adv  = pop;
`endif
        ovf_set = push && full && !pop;
        // A write into a full queue without a pop replaces, so count holds.
        inc     = wr_en && !pop && !full;
        dec     = pop && !wr_en;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (inc) begin
                count <= count + CNT_ONE;
            end else if (dec) begin
                count <= count - CNT_ONE;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
